// File: rtl/alu_pkg.sv
// Shared operation encodings and controller state constants for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_nbit.sv
// WIDTH-bit adder with carry-in and carry-out, shared by every arithmetic path of the ALU.
module adder_nbit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_nbit_seq.sv
// Sequential ALU: single-cycle logic/add/sub/slt, shift-and-add unsigned multiply over WIDTH cycles.
module alu_nbit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             NEG
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             accept;
    logic [WIDTH-1:0] add_x, add_y, add_sum;
    logic             add_ci, add_co;
    logic             add_ovf;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .a    (add_x),
        .b    (add_y),
        .cin  (add_ci),
        .sum  (add_sum),
        .cout (add_co)
    );

    assign accept    = START && (state_q != ST_MUL);
    assign add_ovf   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    assign mul_hi_nx = {add_co, add_sum[WIDTH-1:1]};
    assign mul_lo_nx = {add_sum[0], acc_lo_q[WIDTH-1:1]};

    // The adder serves the multiply accumulate while in ST_MUL, otherwise the live request.
    always_comb begin
        add_x  = A;
        add_y  = B;
        add_ci = CIN;
        if (state_q == ST_MUL) begin
            add_x  = acc_hi_q;
            add_y  = acc_lo_q[0] ? mcand_q : '0;
            add_ci = 1'b0;
        end else if (OP != OP_ADD) begin
            add_y  = ~B;
            add_ci = 1'b1;
        end
    end

    always_comb begin
        op_res = '0;
        case (OP)
            OP_AND:  op_res = A & B;
            OP_OR:   op_res = A | B;
            OP_XOR:  op_res = A ^ B;
            OP_NOR:  op_res = ~(A | B);
            OP_ADD,
            OP_SUB:  op_res = add_sum;
            OP_SLT:  op_res[0] = add_sum[WIDTH-1] ^ add_ovf;
            default: op_res = '0;
        endcase
    end

    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;

        if (state_q == ST_MUL) begin
            acc_hi_d = mul_hi_nx;
            acc_lo_d = mul_lo_nx;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d     = ST_DONE;
                cnt_d       = '0;
                result_d    = mul_lo_nx;
                result_hi_d = mul_hi_nx;
                cout_d      = 1'b0;
                ovf_d       = 1'b0;
                zero_d      = ({mul_hi_nx, mul_lo_nx} == '0);
                neg_d       = mul_hi_nx[WIDTH-1];
            end
        end else begin
            state_d = ST_IDLE;
            if (accept && (OP == OP_MUL)) begin
                state_d  = ST_MUL;
                cnt_d    = '0;
                mcand_d  = A;
                acc_hi_d = '0;
                acc_lo_d = B;
            end else if (accept) begin
                state_d     = ST_DONE;
                result_d    = op_res;
                result_hi_d = '0;
                cout_d      = ((OP == OP_ADD) || (OP == OP_SUB)) ? add_co : 1'b0;
                ovf_d       = ((OP == OP_ADD) || (OP == OP_SUB)) ? add_ovf : 1'b0;
                zero_d      = (op_res == '0);
                neg_d       = op_res[WIDTH-1];
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    assign READY     = (state_q != ST_MUL);
    assign DONE      = (state_q == ST_DONE);
    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;
    assign NEG       = neg_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq at WIDTH=16 using directed vectors with hand-computed results.
module tb_alu_nbit_seq;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] hi;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  OP;
    logic [15:0] A;
    logic [15:0] B;
    logic        CIN;
    logic        READY;
    logic        DONE;
    logic [15:0] RESULT;
    logic [15:0] RESULT_HI;
    logic        COUT;
    logic        OVF;
    logic        ZERO;
    logic        NEG;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    alu_nbit_seq #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .READY     (READY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .COUT      (COUT),
        .OVF       (OVF),
        .ZERO      (ZERO),
        .NEG       (NEG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [15:0] res, input logic [15:0] hi,
                                input logic cout, input logic ovf, input logic zero, input logic neg);
        exp_t e;
        e.name = name; e.res = res; e.hi = hi;
        e.cout = cout; e.ovf = ovf; e.zero = zero; e.neg = neg;
        return e;
    endfunction

    // Monitor: every DONE pops one expectation and compares all result fields.
    always @(negedge CLK) begin
        if (!RESET && DONE) begin
            if (exp_q.size() == 0) begin
                check("unexpected DONE", 32'(DONE), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " RESULT"},    32'(RESULT),    32'(e.res));
                check({e.name, " RESULT_HI"}, 32'(RESULT_HI), 32'(e.hi));
                check({e.name, " COUT"},      32'(COUT),      32'(e.cout));
                check({e.name, " OVF"},       32'(OVF),       32'(e.ovf));
                check({e.name, " ZERO"},      32'(ZERO),      32'(e.zero));
                check({e.name, " NEG"},       32'(NEG),       32'(e.neg));
            end
        end
    end

    // Drives one request across an accept edge; operands are scrambled afterwards to prove latching.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input bit push, input exp_t e);
        START = 1'b1; OP = op; A = a; B = b; CIN = cin;
        @(posedge CLK);
        #1;
        START = 1'b0; OP = OP_NOR; A = 16'hDEAD; B = 16'hBEEF; CIN = 1'b1;
        if (push) exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " READY"},     32'(READY),     32'(1));
        check({tag, " DONE"},      32'(DONE),      32'(0));
        check({tag, " RESULT"},    32'(RESULT),    32'(0));
        check({tag, " RESULT_HI"}, 32'(RESULT_HI), 32'(0));
        check({tag, " COUT"},      32'(COUT),      32'(0));
        check({tag, " OVF"},       32'(OVF),       32'(0));
        check({tag, " ZERO"},      32'(ZERO),      32'(0));
        check({tag, " NEG"},       32'(NEG),       32'(0));
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int lat;
        int low;
        bit seen;
        lat = 0; low = 0; seen = 1'b0;
        issue(OP_MUL, a, b, 1'b0, 1'b1, e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            if (DONE) begin
                seen  = 1'b1;
                START = 1'b0;
                check({e.name, " READY in DONE"}, 32'(READY), 32'(1));
            end else begin
                if (!READY) low++;
                // Requests while busy must be dropped without any trace.
                START = (i % 3 == 0);
                OP    = OP_AND;
                A     = 16'h0F0F;
                B     = 16'hFFFF;
            end
        end
        START = 1'b0;
        check({e.name, " DONE seen"},  32'(seen), 32'(1));
        check({e.name, " latency"},    32'(lat),  32'(17));
        check({e.name, " READY low"},  32'(low),  32'(16));
    endtask

    initial begin
        exp_t none;
        none  = mk("none", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1; START = 1'b0; OP = OP_AND; A = '0; B = '0; CIN = 1'b0;
        #12;
        check_reset_outputs("power-on reset");
        @(negedge CLK);
        RESET = 1'b0;

        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1, mk("add ovf", 16'h8000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        @(negedge CLK);
        // Two requests on consecutive edges: ADD with carry-in then SUB with borrow.
        issue(OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 1'b1, mk("add cin wrap", 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        issue(OP_SUB, 16'h0005, 16'h0007, 1'b0, 1'b1, mk("sub borrow", 16'hFFFE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        issue(OP_SLT, 16'h8000, 16'h0001, 1'b0, 1'b1, mk("slt neg<pos", 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(OP_SLT, 16'h0001, 16'h8000, 1'b0, 1'b1, mk("slt pos<neg", 16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(OP_OR,  16'h00F0, 16'h0F00, 1'b0, 1'b1, mk("or", 16'h0FF0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(OP_XOR, 16'hAAAA, 16'hFFFF, 1'b0, 1'b1, mk("xor", 16'h5555, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(OP_NOR, 16'h0000, 16'h0000, 1'b0, 1'b1, mk("nor", 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge CLK);

        // Asynchronous reset asserted between edges must clear outputs without a clock edge.
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check_reset_outputs("mid-cycle reset");
        @(negedge CLK);
        RESET = 1'b0;

        run_mul(16'hFFFF, 16'hFFFF, mk("mul max", 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        run_mul(16'h0000, 16'h1234, mk("mul zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        run_mul(16'h1234, 16'h0010, mk("mul shift", 16'h2340, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));

        // Abort a multiply five cycles into the run; nothing may be reported for it.
        issue(OP_MUL, 16'h1234, 16'h0010, 1'b0, 1'b0, none);
        repeat (4) @(posedge CLK);
        @(posedge CLK);
        #1;
        check("mul busy before abort", 32'(READY), 32'(0));
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs("mul abort reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        issue(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, mk("and after abort", 16'h3030, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("scoreboard drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
